// File: rtl/rom_pair_stream_reader_if.sv
// Packed word-pair output stream with valid/ready backpressure.
// The master (reader) drives data and valid, and the slave (consumer) drives ready.
interface rom_pair_stream_reader_if #(
    parameter int DATA_WIDTH = 12
);
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic [1:0]              out_keep;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_keep,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_keep,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_pair_stream_reader.sv
// Scans an address window of a dual-port synchronous ROM two words per cycle.
// It re-aligns the returned words with a tag pipeline and buffers them in a credit-tracked FIFO.
module rom_pair_stream_reader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 12,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    input  logic [ADDR_WIDTH:0]      length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    addr_a,
    output logic [ADDR_WIDTH-1:0]    addr_b,
    input  logic [DATA_WIDTH-1:0]    q_a,
    input  logic [DATA_WIDTH-1:0]    q_b,
    rom_pair_stream_reader_if.master strm
);
    // One stage for the address register, then ROM_LATENCY stages matching the ROM.
    localparam int PIPE_DEPTH = ROM_LATENCY + 1;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + PIPE_DEPTH + 2);
    localparam int ENTRY_W    = 2 * DATA_WIDTH + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] REM_TWO = (ADDR_WIDTH+1)'(2);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic                  done_q, done_d;

    logic [PIPE_DEPTH-1:0] tag_v_q;
    logic [PIPE_DEPTH-1:0] tag_last_q;
    logic [1:0]            tag_keep_q [PIPE_DEPTH];

    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    logic [ADDR_WIDTH-1:0] cur_ptr;
    logic [ADDR_WIDTH:0]   cur_rem;
    logic                  issue;
    logic [1:0]            issue_keep;
    logic                  issue_last;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      credit_need;
    logic                  credit_ok;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_nonempty;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            inflight = inflight + CNT_W'(tag_v_q[i]);
        end
    end

    assign fifo_nonempty = (count_q != '0);
    assign fifo_pop      = fifo_nonempty && strm.out_ready;
    assign fifo_push     = tag_v_q[PIPE_DEPTH-1];

    // A pop in this cycle frees its slot for an issue in the same cycle.
    assign credit_need = CNT_W'(count_q) - CNT_W'(fifo_pop) + inflight + CNT_W'(1);
    assign credit_ok   = (credit_need <= CNT_W'(FIFO_DEPTH));

    // The first pair is issued straight from IDLE so the address register
    // is loaded on the same edge that latches the command.
    always_comb begin
        cur_ptr    = (state_q == S_IDLE) ? start_addr : ptr_q;
        cur_rem    = (state_q == S_IDLE) ? length : rem_q;
        issue      = 1'b0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        done_d     = 1'b0;
        issue_keep = (cur_rem >= REM_TWO) ? 2'b11 : 2'b01;
        issue_last = (cur_rem <= REM_TWO);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_RUN: begin
                issue = credit_ok;
            end
            S_DRAIN: begin
                if ((inflight == '0) && (count_q == {{PTR_W{1'b0}}, fifo_pop})) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            addr_a_d = cur_ptr;
            addr_b_d = cur_ptr + 1'b1;
            ptr_d    = cur_ptr + 2'd2;
            rem_d    = cur_rem - ((cur_rem >= REM_TWO) ? REM_TWO : REM_ONE);
            state_d  = issue_last ? S_DRAIN : S_RUN;
        end
    end

    // Discarded lanes are written as zero so the consumer never sees stale data.
    assign fifo_wdata = {
        tag_keep_q[PIPE_DEPTH-1][1] ? q_b : {DATA_WIDTH{1'b0}},
        tag_keep_q[PIPE_DEPTH-1][0] ? q_a : {DATA_WIDTH{1'b0}},
        tag_keep_q[PIPE_DEPTH-1],
        tag_last_q[PIPE_DEPTH-1]
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(fifo_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(fifo_pop);
        count_d  = count_q + (PTR_W+1)'(fifo_push) - (PTR_W+1)'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            done_q   <= 1'b0;
            tag_v_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            done_q   <= done_d;
            tag_v_q  <= {tag_v_q[PIPE_DEPTH-2:0], issue};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_keep_q[0] <= issue_keep;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            tag_keep_q[i] <= tag_keep_q[i-1];
        end
        tag_last_q <= {tag_last_q[PIPE_DEPTH-2:0], issue_last};
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= fifo_wdata;
        end
    end

    assign fifo_head = fifo_mem[rd_ptr_q];

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;

    assign strm.out_valid = fifo_nonempty;
    assign strm.out_data  = fifo_nonempty ? fifo_head[ENTRY_W-1:3] : '0;
    assign strm.out_keep  = fifo_nonempty ? fifo_head[2:1] : 2'b00;
    assign strm.out_last  = fifo_nonempty ? fifo_head[0] : 1'b0;
endmodule

// File: tb/tb_rom_pair_stream_reader.sv
// Randomised bench for rom_pair_stream_reader: a queue-based model of the expected beats
// is built from each accepted command and checked against the stream every cycle.
module tb_rom_pair_stream_reader;
    localparam int AW    = 10;
    localparam int DW    = 12;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [1:0]      keep;
        logic            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q_a, q_b;
    logic [DW-1:0] rom [1024];

    rom_pair_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

    rom_pair_stream_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .addr_a(addr_a), .addr_b(addr_b),
        .q_a(q_a), .q_b(q_b), .strm(strm)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    always @(posedge clk) begin
        q_a <= rom[addr_a];
        q_b <= rom[addr_b];
    end

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t acc_log[$];
    int    cyc = 0;
    bit    m_busy = 0, m_done = 0, after_rst = 0, issued_any = 0;
    int    cmd_cyc = 0, first_valid_cyc = -1, first_acc_cyc = -1, last_acc_cyc = -1;
    int    done_cnt = 0, seen_b1_cnt = 0;
    bit    bp_mode = 0, rand_ready = 0, force_low = 0;
    int    issued_cnt = 0, accepted_cnt = 0;
    logic [AW-1:0] prev_addr_a = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats straight from the command rules: pairs (p, p+1), step 2, wrap mod 1024.
    task automatic model_cmd(input logic [AW-1:0] a, input int len);
        int            rem;
        logic [AW-1:0] p, pb;
        beat_t         b;
        rem = len;
        p   = a;
        while (rem > 0) begin
            pb     = p + 1'b1;
            b.keep = (rem >= 2) ? 2'b11 : 2'b01;
            b.last = (rem <= 2);
            b.data = {(rem >= 2) ? rom[pb] : {DW{1'b0}}, rom[p]};
            exp_q.push_back(b);
            rem = rem - ((rem >= 2) ? 2 : 1);
            p   = p + 2'd2;
        end
    endtask

    // Compare process.
    initial begin
        beat_t         b, g;
        bit            busy_n, done_n;
        logic [AW-1:0] nb;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                m_busy     = 0;
                m_done     = 0;
                after_rst  = 1;
                issued_any = 0;
                prev_addr_a = addr_a;
                continue;
            end
            if (after_rst) begin
                chk("rst_addr_a", addr_a, 0);
                chk("rst_addr_b", addr_b, 0);
                chk("rst_out_valid", strm.out_valid, 0);
                chk("rst_out_data", strm.out_data, 0);
                chk("rst_out_keep", strm.out_keep, 0);
                chk("rst_out_last", strm.out_last, 0);
                after_rst = 0;
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (done) done_cnt++;
            if (addr_a == 0 && addr_b == 1) seen_b1_cnt++;
            if (issued_any) begin
                nb = addr_a + 1'b1;
                chk("addr_b_is_a_plus_1", addr_b, nb);
            end
            if (strm.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("head_data", strm.out_data, exp_q[0].data);
                    chk("head_keep", strm.out_keep, exp_q[0].keep);
                    chk("head_last", strm.out_last, exp_q[0].last);
                end
            end
            if (bp_mode) begin
                if (addr_a != prev_addr_a) issued_cnt++;
                chk("outstanding_le_depth", (issued_cnt - accepted_cnt) <= DEPTH, 1);
            end
            prev_addr_a = addr_a;

            busy_n = m_busy;
            done_n = 0;
            if (strm.out_valid && strm.out_ready && exp_q.size() > 0) begin
                b      = exp_q.pop_front();
                g.data = strm.out_data;
                g.keep = strm.out_keep;
                g.last = strm.out_last;
                acc_log.push_back(g);
                if (bp_mode) accepted_cnt++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                if (b.last) begin
                    busy_n = 0;
                    done_n = 1;
                end
            end
            if (start && !m_busy) begin
                if (length == 0) begin
                    done_n = 1;
                end else begin
                    model_cmd(start_addr, int'(length));
                    busy_n          = 1;
                    issued_any      = 1;
                    cmd_cyc         = cyc;
                    first_valid_cyc = -1;
                    first_acc_cyc   = -1;
                end
            end
            m_busy = busy_n;
            m_done = done_n;
        end
    end

    // Consumer ready driver.
    initial begin
        strm.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (force_low) strm.out_ready = 1'b0;
            else if (rand_ready) strm.out_ready = 1'($urandom_range(0, 1));
            else strm.out_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        length     = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int            base, dc, sb, n, len;
        logic [AW-1:0] a;
        for (int i = 0; i < 1024; i++) rom[i] = DW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single pair.
        base = acc_log.size();
        dc   = done_cnt;
        pulse_start(10'd0, 11'd2);
        wait_idle("single", 100);
        chk("single_beats", acc_log.size() - base, 1);
        chk("single_data", acc_log[base].data, {rom[1], rom[0]});
        chk("single_keep", acc_log[base].keep, 2'b11);
        chk("single_last", acc_log[base].last, 1);
        chk("single_latency", first_valid_cyc - cmd_cyc, LAT + 2);
        chk("single_done_once", done_cnt - dc, 1);
        $display("cmd single addr=0 len=2 beats=%0d", acc_log.size() - base);

        // Odd length crossing the top of the address space.
        base = acc_log.size();
        sb   = seen_b1_cnt;
        pulse_start(10'd1022, 11'd3);
        wait_idle("wrap", 100);
        chk("wrap_beats", acc_log.size() - base, 2);
        chk("wrap_b0_data", acc_log[base].data, {rom[1023], rom[1022]});
        chk("wrap_b0_keep", acc_log[base].keep, 2'b11);
        chk("wrap_b0_last", acc_log[base].last, 0);
        chk("wrap_b1_data", acc_log[base+1].data, {12'h000, rom[0]});
        chk("wrap_b1_keep", acc_log[base+1].keep, 2'b01);
        chk("wrap_b1_last", acc_log[base+1].last, 1);
        chk("wrap_addr_b_1_seen", seen_b1_cnt > sb, 1);
        $display("cmd wrap addr=1022 len=3 beats=%0d", acc_log.size() - base);

        // Whole ROM at full rate.
        base = acc_log.size();
        dc   = done_cnt;
        pulse_start(10'd0, 11'd1024);
        wait_idle("full", 3000);
        chk("full_beats", acc_log.size() - base, 512);
        chk("full_no_bubbles", last_acc_cyc - first_acc_cyc, 511);
        chk("full_latency", first_valid_cyc - cmd_cyc, LAT + 2);
        chk("full_last_data", acc_log[base+511].data, {rom[1023], rom[1022]});
        chk("full_last_last", acc_log[base+511].last, 1);
        chk("full_done_once", done_cnt - dc, 1);
        $display("cmd full addr=0 len=1024 beats=%0d", acc_log.size() - base);

        // Backpressure with a long stall.
        base       = acc_log.size();
        bp_mode    = 1;
        rand_ready = 1;
        pulse_start(10'd500, 11'd20);
        repeat (3) @(posedge clk);
        #1;
        force_low = 1;
        repeat (10) @(posedge clk);
        #1;
        force_low = 0;
        wait_idle("bp", 400);
        chk("bp_beats", acc_log.size() - base, 10);
        bp_mode    = 0;
        rand_ready = 0;
        $display("cmd backpressure addr=500 len=20 beats=%0d", acc_log.size() - base);

        // Zero length, then a start while busy.
        dc = done_cnt;
        pulse_start(10'd7, 11'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0_done_once", done_cnt - dc, 1);
        $display("cmd zero-length addr=7 len=0");
        base = acc_log.size();
        pulse_start(10'd300, 11'd6);
        pulse_start(10'd700, 11'd30);
        wait_idle("busy_start", 200);
        chk("busy_start_beats", acc_log.size() - base, 3);
        chk("busy_start_b0", acc_log[base].data, {rom[301], rom[300]});
        $display("cmd ignored-start addr=300 len=6 beats=%0d", acc_log.size() - base);

        // Reset in the middle of a command.
        base = acc_log.size();
        dc   = done_cnt;
        pulse_start(10'd10, 11'd40);
        n = 0;
        while ((acc_log.size() - base) < 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_wait_beats", n < 200, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - dc, 0);
        base = acc_log.size();
        pulse_start(10'd100, 11'd4);
        wait_idle("post_rst", 100);
        chk("post_rst_beats", acc_log.size() - base, 2);
        chk("post_rst_b0", acc_log[base].data, {rom[101], rom[100]});
        chk("post_rst_b1", acc_log[base+1].data, {rom[103], rom[102]});
        chk("post_rst_b1_last", acc_log[base+1].last, 1);
        $display("cmd after-reset addr=100 len=4 beats=%0d", acc_log.size() - base);

        // Random commands with random consumer stalls.
        rand_ready = 1;
        for (int k = 0; k < 8; k++) begin
            a    = AW'($urandom_range(0, 1023));
            len  = $urandom_range(1, 40);
            base = acc_log.size();
            dc   = done_cnt;
            pulse_start(a, (AW+1)'(len));
            wait_idle("rand", 600);
            chk("rand_beats", acc_log.size() - base, (len + 1) / 2);
            chk("rand_done_once", done_cnt - dc, 1);
            $display("cmd random addr=%0d len=%0d beats=%0d", a, len, acc_log.size() - base);
        end
        rand_ready = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
